instr_cycle_controller: RTL and testbench

Multi-cycle sequencer for the MIPS core. It steps each instruction through FETCH/DECODE/EXECUTE/MEMORY_ACCESS/WRITE_BACK and stalls on Avalon waitrequest and on a busy divider. It generates all register-file write controls: the write enable, the destination index and the writeback source select. It sits between the Avalon memory interface, the PC/IR, and the register file.

---
 rtl/mips_pkg.sv | 44 ++++
 rtl/dest_decoder.sv | 75 +++++++
 rtl/instr_cycle_controller.sv | 111 +++++++++++
 tb/tb_instr_cycle_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the multi-cycle MIPS control path.
// Holds the sequencer state encoding, the opcode / funct / REGIMM-rt
// field values the destination decoder recognises, and the writeback
// source select values driven to the register-file input mux.
package mips_pkg;

    typedef enum logic [2:0] {
        FETCH         = 3'b000,
        DECODE        = 3'b001,
        EXECUTE       = 3'b010,
        MEMORY_ACCESS = 3'b011,
        WRITE_BACK    = 3'b100,
        HALTED        = 3'b101
    } state_t;

    typedef enum logic [5:0] {
        RTYPE  = 6'h00, REGIMM = 6'h01, J     = 6'h02, JAL   = 6'h03,
        BEQ    = 6'h04, BNE    = 6'h05, BLEZ  = 6'h06, BGTZ  = 6'h07,
        ADDIU  = 6'h09, SLTI   = 6'h0a, SLTIU = 6'h0b, ANDI  = 6'h0c,
        ORI    = 6'h0d, XORI   = 6'h0e, LUI   = 6'h0f,
        LB     = 6'h20, LH     = 6'h21, LWL   = 6'h22, LW    = 6'h23,
        LBU    = 6'h24, LHU    = 6'h25, LWR   = 6'h26,
        SB     = 6'h28, SH     = 6'h29, SWL   = 6'h2a, SW    = 6'h2b,
        SWR    = 6'h2e
    } opcode_t;

    typedef enum logic [5:0] {
        JR    = 6'h08, JALR  = 6'h09,
        MFHI  = 6'h10, MTHI  = 6'h11, MFLO = 6'h12, MTLO = 6'h13,
        MULT  = 6'h18, MULTU = 6'h19, DIV  = 6'h1a, DIVU = 6'h1b
    } funct_t;

    typedef enum logic [4:0] {
        BLTZAL = 5'b10000,
        BGEZAL = 5'b10001
    } regimm_t;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    localparam logic [4:0] LINK_REG = 5'd31;

endpackage

// File: rtl/dest_decoder.sv
// dest_decoder: combinational register-write decode of an instruction word.
// Ports:
//   instr     in   32  instruction word
//   has_write out   1  instruction writes a register
//   write_reg out   5  destination register index (0 when no write)
//   wb_sel    out   2  writeback source (WB_ALU / WB_MEM / WB_LINK)
//   is_load   out   1  load, needs a memory read
//   is_store  out   1  store, needs a memory write
//   is_div    out   1  DIV or DIVU, may stall on the divider
module dest_decoder
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output logic        has_write,
    output logic [4:0]  write_reg,
    output logic [1:0]  wb_sel,
    output logic        is_load,
    output logic        is_store,
    output logic        is_div
);

    opcode_t    op;
    funct_t     fn;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_bits;

    assign op          = opcode_t'(instr[31:26]);
    assign fn          = funct_t'(instr[5:0]);
    assign rt          = instr[20:16];
    assign rd          = instr[15:11];
    assign unused_bits = ^{instr[25:21], instr[10:6]};

    always_comb begin
        has_write = 1'b0;
        write_reg = 5'd0;
        wb_sel    = WB_ALU;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_div    = 1'b0;
        case (op)
            RTYPE: begin
                // HI/LO writers and JR leave the register file untouched
                is_div    = fn inside {DIV, DIVU};
                has_write = !(fn inside {JR, MULT, MULTU, DIV, DIVU, MTHI, MTLO});
                write_reg = has_write ? rd : 5'd0;
                wb_sel    = (has_write && fn == JALR) ? WB_LINK : WB_ALU;
            end
            JAL: begin
                has_write = 1'b1;
                write_reg = LINK_REG;
                wb_sel    = WB_LINK;
            end
            REGIMM: begin
                // linking branches write r31 regardless of the branch outcome
                has_write = rt inside {BGEZAL, BLTZAL};
                write_reg = has_write ? LINK_REG : 5'd0;
                wb_sel    = has_write ? WB_LINK : WB_ALU;
            end
            ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI: begin
                has_write = 1'b1;
                write_reg = rt;
            end
            LB, LH, LWL, LW, LBU, LHU, LWR: begin
                has_write = 1'b1;
                write_reg = rt;
                wb_sel    = WB_MEM;
                is_load   = 1'b1;
            end
            SB, SH, SWL, SW, SWR: is_store = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_cycle_controller.sv
// instr_cycle_controller: multi-cycle FETCH/DECODE/EXECUTE/MEMORY_ACCESS/
// WRITE_BACK sequencer with Avalon and divider stalls and halt on PC 0.
// Ports:
//   clk, reset    in      clock, synchronous active-high reset
//   instr         in  32  latched IR contents
//   waitrequest   in   1  Avalon waitrequest
//   div_busy      in   1  divider still computing
//   next_pc_zero  in   1  next PC equals 0
//   state_out     out  3  current state encoding
//   active        out  1  CPU running (0 once halted)
//   mem_read/mem_write/addr_sel/ir_write/pc_write  memory and PC controls
//   reg_write/write_reg/wb_sel                     register-file controls
module instr_cycle_controller
    import mips_pkg::*;
#(
    parameter bit DIV_STALL_EN = 1'b1
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        waitrequest,
    input  logic        div_busy,
    input  logic        next_pc_zero,
    output logic [2:0]  state_out,
    output logic        active,
    output logic        mem_read,
    output logic        mem_write,
    output logic        addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [4:0]  write_reg,
    output logic [1:0]  wb_sel
);

    state_t     state;
    state_t     state_next;
    logic       has_write;
    logic       is_load;
    logic       is_store;
    logic       is_div;
    logic       stall;
    logic [4:0] dec_reg;
    logic [1:0] dec_wb;

    dest_decoder u_dest_decoder (
        .instr     (instr),
        .has_write (has_write),
        .write_reg (dec_reg),
        .wb_sel    (dec_wb),
        .is_load   (is_load),
        .is_store  (is_store),
        .is_div    (is_div)
    );

    assign stall = DIV_STALL_EN && is_div && div_busy;

    always_comb begin
        state_next = state;
        active     = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        addr_sel   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    mem_read   = 1'b1;
                    ir_write   = !waitrequest;
                    state_next = waitrequest ? FETCH : DECODE;
                end
                DECODE: state_next = EXECUTE;
                EXECUTE: if (!stall) begin
                    pc_write   = !(is_load || is_store || has_write);
                    state_next = (is_load || is_store) ? MEMORY_ACCESS :
                                 has_write ? WRITE_BACK : FETCH;
                end
                MEMORY_ACCESS: begin
                    addr_sel  = 1'b1;
                    mem_read  = is_load;
                    mem_write = is_store;
                    if (!waitrequest) begin
                        pc_write   = is_store;
                        state_next = is_load ? WRITE_BACK : FETCH;
                    end
                end
                WRITE_BACK: begin
                    // r0 is not protected by the register file
                    reg_write  = has_write && dec_reg != 5'd0;
                    pc_write   = 1'b1;
                    state_next = FETCH;
                end
                HALTED: active = 1'b0;
                default: state_next = FETCH;
            endcase
            if (pc_write && next_pc_zero)
                state_next = HALTED;
        end
    end

    always_ff @(posedge clk)
        state <= reset ? FETCH : state_next;

    assign state_out = reset ? FETCH : state;
    assign write_reg = reset ? 5'd0 : dec_reg;
    assign wb_sel    = reset ? WB_ALU : dec_wb;

endmodule

// File: tb/tb_instr_cycle_controller.sv
// tb_instr_cycle_controller: per-cycle trace checking of the sequencer.
module tb_instr_cycle_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'd0;
    logic        waitrequest = 1'b1;
    logic        div_busy = 1'b0;
    logic        next_pc_zero = 1'b0;
    logic [2:0]  state_out;
    logic        active, mem_read, mem_write, addr_sel, ir_write, pc_write, reg_write;
    logic [4:0]  write_reg;
    logic [1:0]  wb_sel;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    instr_cycle_controller #(.DIV_STALL_EN(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .waitrequest  (waitrequest),
        .div_busy     (div_busy),
        .next_pc_zero (next_pc_zero),
        .state_out    (state_out),
        .active       (active),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .addr_sel     (addr_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .reg_write    (reg_write),
        .write_reg    (write_reg),
        .wb_sel       (wb_sel)
    );

    // one expected clock cycle: inputs to drive and outputs required
    // sb = {mem_read, mem_write, addr_sel, ir_write, pc_write, reg_write, active}
    typedef struct {
        logic        rst, wr_in, busy, npz;
        logic [31:0] ins;
        logic [2:0]  st;
        logic [6:0]  sb;
        logic        chk_dest;
        logic [4:0]  wreg;
        logic [1:0]  wsel;
    } cyc_t;

    // directed record: instruction, its expected register-write class and
    // destination, and the stall / halt / abort scenario to apply
    // kind: 0 = no write, no memory; 1 = register write; 2 = load; 3 = store
    typedef struct {
        logic [31:0] ins;
        int          kind;
        logic [4:0]  wr;
        logic [1:0]  ws;
        logic        dv;
        int          wf, wx, wm;
        logic        halt;
        int          hold;
        int          abort;
    } vec_t;

    cyc_t q[$];

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic add(input logic rst, wi, bz, nz, input logic [31:0] ins,
                       input logic [2:0] st, input logic [6:0] sb,
                       input logic cd, input logic [4:0] wreg, input logic [1:0] wsel);
        cyc_t c;
        c.rst = rst; c.wr_in = wi; c.busy = bz; c.npz = nz; c.ins = ins;
        c.st = st; c.sb = sb; c.chk_dest = cd; c.wreg = wreg; c.wsel = wsel;
        q.push_back(c);
    endtask

    task automatic rst_cycle(input logic [31:0] ins);
        add(1'b1, 1'b1, rb(), rb(), ins, 3'd0, 7'b0000001, 1'b1, 5'd0, 2'd0);
    endtask

    // expected trace of one instruction from its class and stall scenario
    task automatic gen(input vec_t v);
        logic [6:0] ms;
        for (int i = 0; i < v.wf; i++)
            add(1'b0, 1'b1, rb(), rb(), v.ins, 3'd0, 7'b1000001, 1'b0, 5'd0, 2'd0);
        add(1'b0, 1'b0, rb(), rb(), v.ins, 3'd0, 7'b1001001, 1'b0, 5'd0, 2'd0);
        add(1'b0, rb(), rb(), rb(), v.ins, 3'd1, 7'b0000001, 1'b0, 5'd0, 2'd0);
        for (int i = 0; i < v.wx; i++)
            add(1'b0, rb(), 1'b1, rb(), v.ins, 3'd2, 7'b0000001, 1'b0, 5'd0, 2'd0);
        if (v.kind == 0)
            add(1'b0, rb(), v.dv ? 1'b0 : rb(), v.halt, v.ins, 3'd2, 7'b0000101, 1'b0, 5'd0, 2'd0);
        else
            add(1'b0, rb(), v.dv ? 1'b0 : rb(), rb(), v.ins, 3'd2, 7'b0000001, 1'b0, 5'd0, 2'd0);
        if (v.kind >= 2) begin
            ms = {v.kind == 2, v.kind == 3, 5'b10001};
            for (int i = 0; i < v.wm; i++) begin
                if (i == v.abort) begin
                    rst_cycle(v.ins);
                    return;
                end
                add(1'b0, 1'b1, rb(), rb(), v.ins, 3'd3, ms, 1'b0, 5'd0, 2'd0);
            end
            if (v.abort == v.wm) begin
                rst_cycle(v.ins);
                return;
            end
            if (v.kind == 3)
                add(1'b0, 1'b0, rb(), v.halt, v.ins, 3'd3, ms | 7'b0000100, 1'b0, 5'd0, 2'd0);
            else
                add(1'b0, 1'b0, rb(), rb(), v.ins, 3'd3, ms, 1'b0, 5'd0, 2'd0);
        end
        if (v.kind == 1 || v.kind == 2)
            add(1'b0, rb(), rb(), v.halt, v.ins, 3'd4, {5'b00001, v.wr != 5'd0, 1'b1},
                1'b1, v.wr, v.ws);
        if (v.halt) begin
            for (int i = 0; i < v.hold; i++)
                add(1'b0, rb(), rb(), rb(), v.ins, 3'd5, 7'b0000000, 1'b0, 5'd0, 2'd0);
            rst_cycle(v.ins);
        end
    endtask

    // reference classification of an instruction from the ISA field values
    function automatic void ref_dec(input logic [31:0] i, output int kind,
                                    output logic [4:0] wr, output logic [1:0] ws,
                                    output logic dv);
        logic [5:0] op;
        logic [5:0] fn;
        op = i[31:26];
        fn = i[5:0];
        kind = 0; wr = 5'd0; ws = 2'd0; dv = 1'b0;
        if (op == 6'd0) begin
            dv = fn inside {6'h1a, 6'h1b};
            if (!(fn inside {6'h08, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h11, 6'h13})) begin
                kind = 1; wr = i[15:11]; ws = (fn == 6'h09) ? 2'd2 : 2'd0;
            end
        end else if (op == 6'd3 || (op == 6'd1 && i[20:16] inside {5'd16, 5'd17})) begin
            kind = 1; wr = 5'd31; ws = 2'd2;
        end else if (op inside {[6'h09:6'h0f]}) begin
            kind = 1; wr = i[20:16];
        end else if (op inside {[6'h20:6'h26]}) begin
            kind = 2; wr = i[20:16]; ws = 2'd1;
        end else if (op inside {6'h28, 6'h29, 6'h2a, 6'h2b, 6'h2e}) begin
            kind = 3;
        end
    endfunction

    task automatic run();
        cyc_t c;
        int n = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            reset = c.rst; waitrequest = c.wr_in; div_busy = c.busy;
            next_pc_zero = c.npz; instr = c.ins;
            @(negedge clk);
            total++;
            if ({state_out, mem_read, mem_write, addr_sel, ir_write, pc_write, reg_write, active}
                === {c.st, c.sb})
                passed++;
            else
                $display("FAIL cycle %0d ctrl: got st=%b sb=%b, expected st=%b sb=%b (instr %h)",
                         n, state_out,
                         {mem_read, mem_write, addr_sel, ir_write, pc_write, reg_write, active},
                         c.st, c.sb, c.ins);
            if (c.chk_dest) begin
                total++;
                if ({write_reg, wb_sel} === {c.wreg, c.wsel})
                    passed++;
                else
                    $display("FAIL cycle %0d dest: got write_reg=%0d wb_sel=%0d, expected %0d/%0d (instr %h)",
                             n, write_reg, wb_sel, c.wreg, c.wsel, c.ins);
            end
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        vec_t tbl[15];
        vec_t v;
        int   ops[27];
        int   fns[14];
        int   rts[4];
        tbl[0]  = '{32'h24020005, 1, 5'd2,  2'd0, 1'b0, 2, 0, 0, 1'b0, 0, -1};  // ADDIU, fetch wait
        tbl[1]  = '{32'h8C230004, 2, 5'd3,  2'd1, 1'b0, 0, 0, 3, 1'b0, 0, -1};  // LW, mem wait
        tbl[2]  = '{32'h0C000010, 1, 5'd31, 2'd2, 1'b0, 0, 0, 0, 1'b0, 0, -1};  // JAL
        tbl[3]  = '{32'h04100003, 1, 5'd31, 2'd2, 1'b0, 0, 0, 0, 1'b0, 0, -1};  // BLTZAL
        tbl[4]  = '{32'hAC230004, 3, 5'd0,  2'd0, 1'b0, 0, 0, 1, 1'b0, 0, -1};  // SW
        tbl[5]  = '{32'h00220021, 1, 5'd0,  2'd0, 1'b0, 0, 0, 0, 1'b0, 0, -1};  // ADDU rd=0
        tbl[6]  = '{32'h0022001A, 0, 5'd0,  2'd0, 1'b1, 0, 5, 0, 1'b0, 0, -1};  // DIV busy 5
        tbl[7]  = '{32'h00000008, 0, 5'd0,  2'd0, 1'b0, 0, 0, 0, 1'b1, 10, -1}; // JR $0 halt
        tbl[8]  = '{32'h8C230004, 2, 5'd3,  2'd1, 1'b0, 1, 0, 3, 1'b0, 0, 2};   // LW reset in mem
        tbl[9]  = '{32'h00001012, 1, 5'd2,  2'd0, 1'b0, 0, 0, 0, 1'b0, 0, -1};  // MFLO
        tbl[10] = '{32'h34A5FFFF, 1, 5'd5,  2'd0, 1'b0, 1, 0, 0, 1'b0, 0, -1};  // ORI
        tbl[11] = '{32'h0020F809, 1, 5'd31, 2'd2, 1'b0, 0, 0, 0, 1'b0, 0, -1};  // JALR
        tbl[12] = '{32'h08000000, 0, 5'd0,  2'd0, 1'b0, 0, 0, 0, 1'b0, 0, -1};  // J
        tbl[13] = '{32'h10000000, 0, 5'd0,  2'd0, 1'b0, 0, 0, 0, 1'b0, 0, -1};  // BEQ
        tbl[14] = '{32'h0022001B, 0, 5'd0,  2'd0, 1'b1, 0, 2, 0, 1'b1, 3, -1};  // DIVU halt
        rst_cycle(32'd0);
        rst_cycle(32'd0);
        foreach (tbl[k]) gen(tbl[k]);

        ops = '{0, 0, 0, 0, 1, 1, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13, 14, 15,
                32, 33, 35, 36, 38, 40, 41, 43, 63};
        fns = '{6'h21, 6'h23, 6'h2a, 6'h09, 6'h08, 6'h18, 6'h19,
                6'h1a, 6'h1b, 6'h10, 6'h12, 6'h11, 6'h13, 6'h00};
        rts = '{0, 1, 16, 17};
        for (int n = 0; n < 250; n++) begin
            v.ins = $urandom;
            v.ins[31:26] = 6'(ops[$urandom_range(0, 26)]);
            if (v.ins[31:26] == 6'd0) v.ins[5:0] = 6'(fns[$urandom_range(0, 13)]);
            if (v.ins[31:26] == 6'd1) v.ins[20:16] = 5'(rts[$urandom_range(0, 3)]);
            ref_dec(v.ins, v.kind, v.wr, v.ws, v.dv);
            v.wf    = $urandom_range(0, 2);
            v.wx    = v.dv ? $urandom_range(0, 3) : 0;
            v.wm    = $urandom_range(0, 2);
            v.halt  = ($urandom_range(0, 9) == 0);
            v.hold  = $urandom_range(1, 4);
            v.abort = (v.kind >= 2 && $urandom_range(0, 9) == 0) ? $urandom_range(0, v.wm) : -1;
            gen(v);
        end

        run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
